// File: rtl/fifo_pkg.sv
// Shared constants and width helpers for the synchronous FIFO family.
package fifo_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 8;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // One extra bit over the storage index so full and empty can be told apart.
  localparam int DEF_PTR_W = clog2(DEF_DEPTH) + 1;

endpackage

// File: rtl/fifo_mem_dp.sv
// Simple dual-port storage: one write port, one registered read port, no reset.
module fifo_mem_dp
  import fifo_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Read-before-write on a shared address, which the full-FIFO read+write case needs.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy flags and a registered read path.
// Define SYNC_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = DEF_DEPTH,
  parameter  int AF_LVL = 6,
  parameter  int AE_LVL = 1,
  localparam int ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  ,
  output logic              overflow,
  output logic              underflow
`endif
);

  localparam logic [ADDR_W:0] AF_CNT = (ADDR_W+1)'(AF_LVL);
  localparam logic [ADDR_W:0] AE_CNT = (ADDR_W+1)'(AE_LVL);

  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              rd_valid_q;
  logic              rd_seen_q;
  logic              rd_acc, wr_acc;
  logic [DATA_W-1:0] mem_rdata;

  assign empty        = (wr_ptr_q == rd_ptr_q);
  assign full         = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                        (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign almost_full  = (count_q >= AF_CNT);
  assign almost_empty = (count_q <= AE_CNT);
  assign count        = count_q;
  assign rd_valid     = rd_valid_q;

  always_comb begin
    rd_acc   = rd_en && !empty;
    wr_acc   = wr_en && (!full || rd_acc);
    wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_seen_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_acc;
      rd_seen_q  <= rd_seen_q | rd_acc;
    end
  end

  // The RAM output register has no reset; mask it until a read lands after reset.
  assign rd_data = rd_seen_q ? mem_rdata : '0;

  fifo_mem_dp #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (wr_acc),
    .wr_addr_i (wr_ptr_q[ADDR_W-1:0]),
    .wr_data_i (wr_data),
    .rd_en_i   (rd_acc),
    .rd_addr_i (rd_ptr_q[ADDR_W-1:0]),
    .rd_data_o (mem_rdata)
  );

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic overflow_q, underflow_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_en && full && !rd_acc) overflow_q  <= 1'b1;
      if (rd_en && empty)           underflow_q <= 1'b1;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Randomised and directed bench for sync_fifo_param against a queue-based model.
module tb_sync_fifo_param;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int AF_LVL = 6;
  localparam int AE_LVL = 1;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              wr_en = 1'b0;
  logic              rd_en = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid, full, empty, almost_full, almost_empty;
  logic [ADDR_W:0]   count;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic              overflow, underflow;
`endif

  always #5 clk = ~clk;

  sync_fifo_param #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AF_LVL (AF_LVL),
    .AE_LVL (AE_LVL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    .overflow     (overflow),
    .underflow    (underflow)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit run_cmp = 1'b0;

  // Reference model: contents as a queue, read word and strobe as plain variables.
  logic [DATA_W-1:0] mq[$];
  logic [DATA_W-1:0] m_rd_data;
  bit m_rd_valid, m_ovf, m_udf, m_racc, m_wacc;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_rd_data  = '0;
      m_rd_valid = 1'b0;
      m_ovf      = 1'b0;
      m_udf      = 1'b0;
    end else begin
      m_racc = rd_en && (mq.size() != 0);
      m_wacc = wr_en && ((mq.size() < DEPTH) || m_racc);
      if (wr_en && mq.size() == DEPTH && !m_racc) m_ovf = 1'b1;
      if (rd_en && mq.size() == 0) m_udf = 1'b1;
      m_rd_valid = m_racc;
      if (m_racc) m_rd_data = mq.pop_front();
      if (m_wacc) mq.push_back(wr_data);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run_cmp && !rst) begin
      chk("count",        64'(count),        64'(mq.size()));
      chk("full",         64'(full),         64'(mq.size() == DEPTH));
      chk("empty",        64'(empty),        64'(mq.size() == 0));
      chk("almost_full",  64'(almost_full),  64'(mq.size() >= AF_LVL));
      chk("almost_empty", 64'(almost_empty), 64'(mq.size() <= AE_LVL));
      chk("rd_valid",     64'(rd_valid),     64'(m_rd_valid));
      chk("rd_data",      64'(rd_data),      64'(m_rd_data));
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      chk("overflow",     64'(overflow),     64'(m_ovf));
      chk("underflow",    64'(underflow),    64'(m_udf));
`endif
    end
  end

  task automatic cyc(input bit w, input logic [DATA_W-1:0] d, input bit r);
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"},    64'(count),        64'd0);
    chk({tag, "_empty"},    64'(empty),        64'd1);
    chk({tag, "_full"},     64'(full),         64'd0);
    chk({tag, "_aempty"},   64'(almost_empty), 64'd1);
    chk({tag, "_afull"},    64'(almost_full),  64'd0);
    chk({tag, "_rd_valid"}, 64'(rd_valid),     64'd0);
    chk({tag, "_rd_data"},  64'(rd_data),      64'd0);
  endtask

  initial begin
    #2 rst = 1'b1;
    #1 chk_reset_state("rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_cmp = 1'b1;
    repeat (2) cyc(1'b0, '0, 1'b0);
    chk_reset_state("idle");

    // Fill to full; one extra write must be dropped.
    for (int k = 1; k <= 8; k++) begin
      cyc(1'b1, 32'h11 * k, 1'b0);
      if (k == 5) chk("afull_at5", 64'(almost_full), 64'd0);
      if (k == 6) chk("afull_at6", 64'(almost_full), 64'd1);
    end
    chk("fill_full",  64'(full),  64'd1);
    chk("fill_count", 64'(count), 64'd8);
    cyc(1'b1, 32'h99, 1'b0);
    chk("ovf_count", 64'(count), 64'd8);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    chk("ovf_flag", 64'(overflow), 64'd1);
`endif

    // Drain in order, then one read from empty.
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, '0, 1'b1);
      chk("drain_valid", 64'(rd_valid), 64'd1);
      chk("drain_data",  64'(rd_data),  64'(32'h11 * i));
    end
    chk("drain_empty", 64'(empty), 64'd1);
    cyc(1'b0, '0, 1'b1);
    chk("udf_valid", 64'(rd_valid), 64'd0);
    chk("udf_hold",  64'(rd_data),  64'h88);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    chk("udf_flag", 64'(underflow), 64'd1);
`endif

    // Simultaneous read+write while full.
    for (int k = 1; k <= 8; k++) cyc(1'b1, 32'h11 * k, 1'b0);
    cyc(1'b1, 32'hAA, 1'b1);
    chk("fullrw_count", 64'(count),   64'd8);
    chk("fullrw_data",  64'(rd_data), 64'h11);
    for (int i = 2; i <= 8; i++) begin
      cyc(1'b0, '0, 1'b1);
      chk("fullrw_seq", 64'(rd_data), 64'(32'h11 * i));
    end
    cyc(1'b0, '0, 1'b1);
    chk("fullrw_aa",    64'(rd_data), 64'hAA);
    chk("fullrw_empty", 64'(empty),   64'd1);

    // Simultaneous read+write while empty: no bypass.
    cyc(1'b1, 32'h5A, 1'b1);
    chk("emptyrw_valid", 64'(rd_valid), 64'd0);
    chk("emptyrw_count", 64'(count),    64'd1);
    chk("emptyrw_hold",  64'(rd_data),  64'hAA);
    cyc(1'b0, '0, 1'b1);
    chk("emptyrw_data",  64'(rd_data),  64'h5A);
    chk("emptyrw_valid2", 64'(rd_valid), 64'd1);

    // Pointer wrap at constant occupancy 3.
    for (int k = 0; k < 3; k++) cyc(1'b1, $urandom, 1'b0);
    for (int k = 0; k < 20; k++) begin
      cyc(1'b1, $urandom, 1'b1);
      chk("wrap_count", 64'(count), 64'd3);
    end
    for (int k = 0; k < 3; k++) cyc(1'b0, '0, 1'b1);

    // Random traffic: write-biased, read-biased, then balanced.
    for (int k = 0; k < 600; k++) begin
      int wp, rp;
      wp = (k < 200) ? 80 : (k < 400) ? 25 : 50;
      rp = (k < 200) ? 25 : (k < 400) ? 80 : 50;
      cyc($urandom_range(0, 99) < wp, $urandom, $urandom_range(0, 99) < rp);
    end

    // Reset in the middle of traffic.
    for (int k = 0; k < 4; k++) cyc(1'b1, 32'hC0 + k, 1'b0);
    cyc(1'b1, 32'hC4, 1'b1);
    wr_en = 1'b1;
    rd_en = 1'b1;
    #2 rst = 1'b1;
    #1 chk_reset_state("midrst");
    wr_en = 1'b0;
    rd_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b1, 32'h77, 1'b0);
    cyc(1'b0, '0, 1'b1);
    chk("post_rst_data", 64'(rd_data), 64'h77);
    repeat (2) cyc(1'b0, '0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
